// File: rtl/tcu_kstep_sequencer.sv
// K-step sequencer for the TCU fused dot-product unit: streams operand beats and carries the FEDP result
// back as the next addend. Define TCU_KSTEP_PERF_EN to add the perf_steps/perf_stalls counters.
module tcu_kstep_sequencer #(
  parameter int N       = 4,
  parameter int LATENCY = 4,
  parameter int STEPW   = 4,
  parameter int XLEN    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_fmt_s,
  input  logic [3:0]          req_fmt_d,
  input  logic [STEPW-1:0]    req_steps,
  input  logic [XLEN-1:0]     req_c,
  input  logic                beat_valid,
  output logic                beat_ready,
  input  logic [N*XLEN-1:0]   beat_a,
  input  logic [N*XLEN-1:0]   beat_b,
  output logic                fedp_enable,
  output logic [3:0]          fedp_fmt_s,
  output logic [3:0]          fedp_fmt_d,
  output logic [N*XLEN-1:0]   fedp_a_row,
  output logic [N*XLEN-1:0]   fedp_b_col,
  output logic [XLEN-1:0]     fedp_c_val,
  input  logic [XLEN-1:0]     fedp_d_val,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [XLEN-1:0]     rsp_d
`ifdef TCU_KSTEP_PERF_EN
  ,
  output logic [31:0]         perf_steps,
  output logic [31:0]         perf_stalls
`endif
);

  localparam int WAITW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q;
  logic [XLEN-1:0]  acc_q;
  logic [STEPW-1:0] steps_q;
  logic [WAITW-1:0] wait_q;
  logic [3:0]       fmt_s_q;
  logic [3:0]       fmt_d_q;
  logic             capture_s;

  // The cycle in which the FEDP result for the current step is valid and gets folded into acc.
  assign capture_s = (LATENCY == 0) ? ((state_q == S_ISSUE) && beat_valid)
                                    : ((state_q == S_WAIT) && (wait_q == WAITW'(1)));

  // Job sequencing FSM: request latch, beat issue, latency wait, response hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      steps_q <= '0;
      wait_q  <= '0;
      fmt_s_q <= 4'd0;
      fmt_d_q <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            fmt_s_q <= req_fmt_s;
            fmt_d_q <= req_fmt_d;
            steps_q <= req_steps;
            acc_q   <= req_c;
            state_q <= (req_steps == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (beat_valid) begin
            if (LATENCY == 0) begin
              acc_q   <= fedp_d_val;
              steps_q <= steps_q - STEPW'(1);
              state_q <= (steps_q == STEPW'(1)) ? S_DONE : S_ISSUE;
            end else begin
              wait_q  <= WAITW'(LATENCY);
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          wait_q <= wait_q - WAITW'(1);
          if (capture_s) begin
            acc_q   <= fedp_d_val;
            steps_q <= steps_q - STEPW'(1);
            state_q <= (steps_q == STEPW'(1)) ? S_DONE : S_ISSUE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Enable stays high from the issue cycle until the cycle before the result is captured.
  assign fedp_enable = ((state_q == S_ISSUE) && beat_valid) ||
                       ((state_q == S_WAIT) && (wait_q > WAITW'(1)));

  assign req_ready  = (state_q == S_IDLE);
  assign beat_ready = (state_q == S_ISSUE);
  assign rsp_valid  = (state_q == S_DONE);
  assign rsp_d      = acc_q;
  assign fedp_c_val = acc_q;
  assign fedp_fmt_s = fmt_s_q;
  assign fedp_fmt_d = fmt_d_q;
  assign fedp_a_row = beat_a;
  assign fedp_b_col = beat_b;

`ifdef TCU_KSTEP_PERF_EN
  logic [31:0] perf_steps_q;
  logic [31:0] perf_stalls_q;
  logic        stall_s;

  assign stall_s = (state_q == S_ISSUE) && !beat_valid;

  // Free-running event counters, wrapping naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_steps_q  <= 32'd0;
      perf_stalls_q <= 32'd0;
    end else begin
      if (capture_s) begin
        perf_steps_q <= perf_steps_q + 32'd1;
      end
      if (stall_s) begin
        perf_stalls_q <= perf_stalls_q + 32'd1;
      end
    end
  end

  assign perf_steps  = perf_steps_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_tcu_kstep_sequencer.sv
// Directed bench for tcu_kstep_sequencer: one LATENCY=4 and one LATENCY=0 instance, each with an int8 FEDP model.
module tb_tcu_kstep_sequencer;

  localparam int STEPW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  bit          sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_fmt_s = 4'd0;
  logic [3:0]  req_fmt_d = 4'd0;
  logic [3:0]  req_steps = 4'd0;
  logic [31:0] req_c = 32'd0;
  logic        beat_valid = 1'b0;
  logic [31:0] beat_a = 32'd0;
  logic [31:0] beat_b = 32'd0;
  logic        rsp_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic        rr4, br4, en4, rv4, rr0, br0, en0, rv0;
  logic [3:0]  fs4, fd4, fs0, fd0;
  logic [31:0] a4, b4, c4, d4, rd4, a0, b0, c0, d0, rd0;
  logic        reqv4, reqv0;
`ifdef TCU_KSTEP_PERF_EN
  logic [31:0] ps4, pt4, ps0, pt0;
`endif

  assign reqv4 = req_valid & ~sel;
  assign reqv0 = req_valid & sel;

  tcu_kstep_sequencer #(.N(1), .LATENCY(4), .STEPW(STEPW), .XLEN(32)) u_dut4 (
    .clk(clk), .reset(reset), .req_valid(reqv4), .req_ready(rr4),
    .req_fmt_s(req_fmt_s), .req_fmt_d(req_fmt_d), .req_steps(req_steps), .req_c(req_c),
    .beat_valid(beat_valid), .beat_ready(br4), .beat_a(beat_a), .beat_b(beat_b),
    .fedp_enable(en4), .fedp_fmt_s(fs4), .fedp_fmt_d(fd4), .fedp_a_row(a4), .fedp_b_col(b4),
    .fedp_c_val(c4), .fedp_d_val(d4), .rsp_valid(rv4), .rsp_ready(rsp_ready), .rsp_d(rd4)
`ifdef TCU_KSTEP_PERF_EN
    , .perf_steps(ps4), .perf_stalls(pt4)
`endif
  );

  tcu_kstep_sequencer #(.N(1), .LATENCY(0), .STEPW(STEPW), .XLEN(32)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(reqv0), .req_ready(rr0),
    .req_fmt_s(req_fmt_s), .req_fmt_d(req_fmt_d), .req_steps(req_steps), .req_c(req_c),
    .beat_valid(beat_valid), .beat_ready(br0), .beat_a(beat_a), .beat_b(beat_b),
    .fedp_enable(en0), .fedp_fmt_s(fs0), .fedp_fmt_d(fd0), .fedp_a_row(a0), .fedp_b_col(b0),
    .fedp_c_val(c0), .fedp_d_val(d0), .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_d(rd0)
`ifdef TCU_KSTEP_PERF_EN
    , .perf_steps(ps0), .perf_stalls(pt0)
`endif
  );

  // int8 x4 dot product plus addend, wrapping to 32 bits
  function automatic logic [31:0] dot(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    int s;
    s = int'(c);
    for (int i = 0; i < 4; i++) s += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
    return s;
  endfunction

  logic [31:0] pipe4 [4];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) pipe4[i] <= 32'd0;
    end else if (en4) begin
      pipe4[0] <= dot(a4, b4, c4);
      for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
    end
  end
  assign d4 = pipe4[3];
  assign d0 = dot(a0, b0, c0);

  logic        cur_rr, cur_br, cur_en, cur_rv;
  logic [3:0]  cur_fs, cur_fd;
  logic [31:0] cur_c, cur_rd;
  assign cur_rr = sel ? rr0 : rr4;
  assign cur_br = sel ? br0 : br4;
  assign cur_en = sel ? en0 : en4;
  assign cur_rv = sel ? rv0 : rv4;
  assign cur_fs = sel ? fs0 : fs4;
  assign cur_fd = sel ? fd0 : fd4;
  assign cur_c  = sel ? c0 : c4;
  assign cur_rd = sel ? rd0 : rd4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit              sel;
    int              steps;
    logic [31:0]     c;
    logic [2:0][31:0] a;
    logic [2:0][31:0] b;
    int              stall;
    int              hold;
    logic [31:0]     exp_d;
    int              exp_cyc;
  } vec_t;

  function automatic vec_t mkv(input bit s, input int st, input logic [31:0] c,
                               input logic [31:0] a0v, input logic [31:0] b0v,
                               input logic [31:0] a1v, input logic [31:0] b1v,
                               input logic [31:0] a2v, input logic [31:0] b2v,
                               input int stall, input int hold, input logic [31:0] ed, input int ec);
    vec_t v;
    v.sel = s; v.steps = st; v.c = c;
    v.a[0] = a0v; v.b[0] = b0v; v.a[1] = a1v; v.b[1] = b1v; v.a[2] = a2v; v.b[2] = b2v;
    v.stall = stall; v.hold = hold; v.exp_d = ed; v.exp_cyc = ec;
    return v;
  endfunction

  task automatic run_job(input vec_t v);
    int idx, i2, cyc, stalls_left;
    bit done;
    logic [31:0] p_steps0, p_stalls0;
    sel = v.sel; idx = 0; cyc = 0; done = 1'b0; stalls_left = v.stall;
    p_steps0 = 32'd0; p_stalls0 = 32'd0;
    @(negedge clk);
`ifdef TCU_KSTEP_PERF_EN
    p_steps0 = sel ? ps0 : ps4;
    p_stalls0 = sel ? pt0 : pt4;
`endif
    req_steps = 4'(v.steps);
    req_c = v.c; req_fmt_s = 4'b1001; req_fmt_d = 4'b0011; req_valid = 1'b1;
    beat_valid = 1'b1; beat_a = v.a[0]; beat_b = v.b[0];
    check("req_ready_idle", {31'd0, cur_rr}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check("fmt_s_latched", {28'd0, cur_fs}, 32'h9);
        check("fmt_d_latched", {28'd0, cur_fd}, 32'h3);
        check("c_val_loaded", cur_c, v.c);
      end
      if (cur_rv) begin
        done = 1'b1;
      end else if (cur_br) begin
        i2 = (idx > 2) ? 2 : idx;
        beat_a = v.a[i2]; beat_b = v.b[i2];
        if (idx == 1 && stalls_left > 0) begin
          beat_valid = 1'b0;
          stalls_left--;
        end else begin
          beat_valid = 1'b1;
          idx++;
        end
      end
    end
    check("rsp_seen", {31'd0, done}, 32'd1);
    check("rsp_latency", 32'(cyc), 32'(v.exp_cyc));
    check("beats_taken", 32'(idx), 32'(v.steps));
    check("rsp_d", cur_rd, v.exp_d);
`ifdef TCU_KSTEP_PERF_EN
    check("perf_steps", (sel ? ps0 : ps4) - p_steps0, 32'(v.steps));
    check("perf_stalls", (sel ? pt0 : pt4) - p_stalls0, 32'(v.stall));
`endif
    beat_valid = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check("hold_rsp_valid", {31'd0, cur_rv}, 32'd1);
      check("hold_rsp_d", cur_rd, v.exp_d);
      check("hold_req_ready", {30'd0, cur_rr, cur_br}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("after_rsp_valid", {31'd0, cur_rv}, 32'd0);
    check("after_req_ready", {31'd0, cur_rr}, 32'd1);
  endtask

  vec_t vecs [9];
  bit   seen_rsp;

  initial begin
    vecs[0] = mkv(1'b0, 2, 32'd5, 32'h01010101, 32'h02020202, 32'h01010101, 32'h02020202,
                  32'h0, 32'h0, 0, 5, 32'd21, 11);
    vecs[1] = mkv(1'b0, 0, 32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h3F800000, 1);
    vecs[2] = mkv(1'b1, 3, 32'd0, 32'h1, 32'h1, 32'h2, 32'h1, 32'h3, 32'h1, 0, 0, 32'd6, 4);
    vecs[3] = mkv(1'b0, 2, 32'd5, 32'h01010101, 32'h02020202, 32'h01010101, 32'h02020202,
                  32'h0, 32'h0, 3, 0, 32'd21, 14);
    vecs[4] = mkv(1'b0, 3, 32'd100, 32'h000000FF, 32'h5, 32'h7F7F7F7F, 32'h01010101,
                  32'h80808080, 32'h01010101, 0, 0, 32'h5B, 16);
    vecs[5] = mkv(1'b1, 1, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 32'd0, 2);
    vecs[6] = mkv(1'b1, 0, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 2, 32'h12345678, 1);
    vecs[7] = mkv(1'b1, 3, 32'd10, 32'h1, 32'h1, 32'h2, 32'h1, 32'h3, 32'h1, 2, 0, 32'd16, 6);
    vecs[8] = mkv(1'b1, 15, 32'd0, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 0, 0, 32'd15, 16);

    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, rr4}, 32'd1);
    check("rst_outs4", {28'd0, br4, rv4, en4, 1'b0}, 32'd0);
    check("rst_outs0", {28'd0, br0, rv0, en0, 1'b0}, 32'd0);
    check("rst_acc", c4, 32'd0);
    check("rst_fmt", {24'd0, fs4, fd4}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_job(vecs[i]);

    // Abort a three-step job while step 2 is waiting on the FEDP.
    sel = 1'b0;
    @(negedge clk);
    req_steps = 4'd3; req_c = 32'd0; req_fmt_s = 4'b1001; req_fmt_d = 4'b0011;
    req_valid = 1'b1; beat_valid = 1'b1; beat_a = 32'h1; beat_b = 32'h1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_in_wait_en", {30'd0, en4, br4}, 32'h2);
    check("abort_partial_acc", c4, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_req_ready", {31'd0, rr4}, 32'd1);
    check("abort_outs", {29'd0, br4, rv4, en4}, 32'd0);
    check("abort_acc", c4, 32'd0);
    check("abort_fmt", {24'd0, fs4, fd4}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_rsp = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rv4 || c4 != 32'd0 || !rr4) seen_rsp = 1'b1;
    end
    check("abort_stays_idle", {31'd0, seen_rsp}, 32'd0);
    run_job(mkv(1'b0, 1, 32'd7, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 32'd8, 6));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
